// File: rtl/econet_pkg.sv
// Shared register map, bit positions and byte-lane helpers for the Econet
// hardware control block.
package econet_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned COUNT_W = 8;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_HIGH   = 2'd2,
        REG_STATUS = 2'd3
    } reg_addr_e;

    localparam int unsigned CTRL_CLKEN  = 0;
    localparam int unsigned CTRL_TERMEN = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_INVERT = 3;

    localparam int unsigned STAT_STICKY  = 0;
    localparam int unsigned STAT_LEVEL   = 1;
    localparam int unsigned STAT_CLR_CNT = 2;
    localparam int unsigned STAT_CNT_LSB = 8;

    // Replace only the byte lanes enabled in wr, keeping the rest of old.
    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] data,
                                                      input logic [3:0]        wr);
        logic [DATA_W-1:0] mask;
        mask = {{8{wr[3]}}, {8{wr[2]}}, {8{wr[1]}}, {8{wr[0]}}};
        return (old & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/econet_hwctl_v2_if.sv
// Register bus between the host and the Econet hardware control block.
interface econet_hwctl_v2_if;
    import econet_pkg::*;

    logic              select;
    logic [3:0]        wr;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output select, wr, addr, data_in, input data_out);
    modport slave  (input select, wr, addr, data_in, output data_out);
endinterface

// File: rtl/econet_clkgen.sv
// Econet line clock generator: free-running counter with shadowed period and
// high time so reprogramming only takes effect on a period boundary.
module econet_clkgen #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEF_PERIOD = 99,
    parameter int unsigned DEF_HIGH   = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clken,
    input  logic             invert,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    output logic             clkout
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_sh_q;
    logic [CNT_W-1:0] high_sh_q;
    logic             restart;
    logic             raw;

    // Shadows follow the programmed values while idle and at every wrap.
    assign restart = !clken || (cnt_q == period_sh_q);
    assign raw     = cnt_q < high_sh_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            period_sh_q <= CNT_W'(DEF_PERIOD);
            high_sh_q   <= CNT_W'(DEF_HIGH);
            clkout      <= 1'b0;
        end else begin
            clkout <= clken & (raw ^ invert);
            if (restart) begin
                cnt_q       <= '0;
                period_sh_q <= period;
                high_sh_q   <= high;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/econet_hwctl_v2.sv
// Econet hardware control: register file, clock generator and synchronised
// collision detector with sticky interrupt and saturating event count.
module econet_hwctl_v2
    import econet_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEF_PERIOD  = 99,
    parameter int unsigned DEF_HIGH    = 25,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    econet_hwctl_v2_if.slave   bus,
    input  logic               collision_detect,
    output logic               econet_clken,
    output logic               econet_termen,
    output logic               econet_clkout,
    output logic               coldet_interrupt
);

    logic [CTRL_W-1:0]      ctrl_q;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       high_q;
    logic                   sticky_q;
    logic [COUNT_W-1:0]     count_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   col_sync;
    logic                   col_event;
    logic                   wr_en;
    logic                   status_wr;
    logic                   clr_sticky;
    logic                   clr_count;
    reg_addr_e              addr;

    assign addr       = reg_addr_e'(bus.addr);
    assign wr_en      = bus.select && (bus.wr != 4'b0000);
    assign status_wr  = wr_en && bus.wr[0] && (addr == REG_STATUS);
    assign clr_sticky = status_wr && bus.data_in[STAT_STICKY];
    assign clr_count  = status_wr && bus.data_in[STAT_CLR_CNT];
    assign col_sync   = sync_q[SYNC_STAGES-1];
    assign col_event  = armed_q && col_sync && !prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q   <= '0;
            period_q <= CNT_W'(DEF_PERIOD);
            high_q   <= CNT_W'(DEF_HIGH);
        end else if (wr_en) begin
            case (addr)
                REG_CTRL:   if (bus.wr[0]) ctrl_q <= bus.data_in[CTRL_W-1:0];
                REG_PERIOD: period_q <= CNT_W'(merge_lanes(DATA_W'(period_q), bus.data_in, bus.wr));
                REG_HIGH:   high_q   <= CNT_W'(merge_lanes(DATA_W'(high_q), bus.data_in, bus.wr));
                default:    ;
            endcase
        end
    end

    // Edge detection arms only once a settled low level has been observed,
    // so a collision held high through reset release is not counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], collision_detect};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= col_sync;
            if (fill_q[SYNC_STAGES-1] && !col_sync) armed_q <= 1'b1;
        end
    end

    // A new event wins over a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= col_event | (sticky_q & ~clr_sticky);
            if (clr_count) begin
                count_q <= col_event ? COUNT_W'(1) : '0;
            end else if (col_event && (count_q != '1)) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.data_out = '0;
        case (addr)
            REG_CTRL:   bus.data_out[CTRL_W-1:0] = ctrl_q;
            REG_PERIOD: bus.data_out = DATA_W'(period_q);
            REG_HIGH:   bus.data_out = DATA_W'(high_q);
            REG_STATUS: begin
                bus.data_out[STAT_STICKY]              = sticky_q;
                bus.data_out[STAT_LEVEL]               = col_sync;
                bus.data_out[STAT_CNT_LSB +: COUNT_W]  = count_q;
            end
            default:    ;
        endcase
    end

    assign econet_clken     = ctrl_q[CTRL_CLKEN];
    assign econet_termen    = ctrl_q[CTRL_TERMEN];
    assign coldet_interrupt = sticky_q & ctrl_q[CTRL_IRQ_EN];

    econet_clkgen #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_HIGH   (DEF_HIGH)
    ) u_clkgen (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (ctrl_q[CTRL_CLKEN]),
        .invert  (ctrl_q[CTRL_INVERT]),
        .period  (period_q),
        .high    (high_q),
        .clkout  (econet_clkout)
    );

endmodule

// File: tb/tb_econet_hwctl_v2.sv
// Directed self-checking bench for econet_hwctl_v2: registers, clock
// generator timing, collision interrupt/count and reset behaviour.
module tb_econet_hwctl_v2;

    logic clk;
    logic reset_n;
    logic collision_detect;
    logic econet_clken;
    logic econet_termen;
    logic econet_clkout;
    logic coldet_interrupt;

    int n_checks;
    int n_pass;
    logic cap [0:255];
    logic [31:0] rd;

    econet_hwctl_v2_if bus ();

    econet_hwctl_v2 #(
        .CNT_W       (16),
        .DEF_PERIOD  (99),
        .DEF_HIGH    (25),
        .SYNC_STAGES (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus),
        .collision_detect (collision_detect),
        .econet_clken     (econet_clken),
        .econet_termen    (econet_termen),
        .econet_clkout    (econet_clkout),
        .coldet_interrupt (coldet_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic reg_write(input logic [1:0] a, input logic [31:0] d,
                             input logic [3:0] w, input logic sel);
        bus.select  = sel;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        @(negedge clk);
        bus.select  = 1'b0;
        bus.wr      = 4'b0000;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        rd = bus.data_out;
        check(tag, rd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            cap[k] = econet_clkout;
            @(negedge clk);
        end
    endtask

    function automatic int highs(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (cap[k]) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hi_val [0:3];
        logic        inv    [0:3];
        int          exp_hi [0:3];
        hi_val = '{16'd0, 16'd20, 16'd0, 16'd20};
        inv    = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_hi = '{0, 20, 20, 0};

        n_checks = 0;
        n_pass   = 0;
        reset_n = 1'b0;
        collision_detect = 1'b0;
        bus.select = 1'b0;
        bus.wr = 4'b0000;
        bus.addr = 2'd0;
        bus.data_in = 32'h0;
        idle(3);

        check("reset_outputs", {28'h0, econet_clken, econet_termen, econet_clkout, coldet_interrupt}, 32'h0);
        read_check("reset_ctrl",   2'd0, 32'h0);
        read_check("reset_period", 2'd1, 32'd99);
        read_check("reset_high",   2'd2, 32'd25);
        read_check("reset_status", 2'd3, 32'h0);
        reset_n = 1'b1;
        idle(4);

        // Byte lanes, deselected and zero-strobe writes
        reg_write(2'd1, 32'h0000_1234, 4'b0010, 1'b1);
        read_check("period_lane1", 2'd1, 32'h0000_1263);
        reg_write(2'd1, 32'hFFFF_FFFF, 4'b1111, 1'b0);
        read_check("period_nosel", 2'd1, 32'h0000_1263);
        reg_write(2'd1, 32'hFFFF_FFFF, 4'b0000, 1'b1);
        read_check("period_nowr", 2'd1, 32'h0000_1263);
        reg_write(2'd1, 32'd99, 4'b1111, 1'b1);

        // Default 100-cycle period, 25 high
        reg_write(2'd0, 32'h1, 4'b0001, 1'b1);
        check("clken_out", {31'h0, econet_clken}, 32'h1);
        capture(202);
        check("def_first_low",  {31'h0, cap[0]},   32'h0);
        check("def_first_high", {31'h0, cap[1]},   32'h1);
        check("def_high_end",   {31'h0, cap[25]},  32'h1);
        check("def_low_start",  {31'h0, cap[26]},  32'h0);
        check("def_high_cnt",   32'(highs(1, 100)), 32'd25);
        check("def_period",     {31'h0, cap[101]}, 32'h1);
        check("def_high_cnt2",  32'(highs(101, 200)), 32'd25);

        // HIGH reprogrammed mid-period takes effect at the next period
        reg_write(2'd0, 32'h0, 4'b0001, 1'b1);
        reg_write(2'd1, 32'd9, 4'b1111, 1'b1);
        reg_write(2'd2, 32'd5, 4'b1111, 1'b1);
        reg_write(2'd0, 32'h1, 4'b0001, 1'b1);
        idle(2);
        reg_write(2'd2, 32'd2, 4'b1111, 1'b1);
        capture(20);
        check("mid_cur_high",  {31'h0, cap[2]},  32'h1);
        check("mid_cur_low",   {31'h0, cap[3]},  32'h0);
        check("mid_cur_tail",  {31'h0, cap[7]},  32'h0);
        check("mid_next_h0",   {31'h0, cap[8]},  32'h1);
        check("mid_next_h1",   {31'h0, cap[9]},  32'h1);
        check("mid_next_low",  {31'h0, cap[10]}, 32'h0);
        check("mid_next_cnt",  32'(highs(8, 17)), 32'd2);
        read_check("mid_high_rb", 2'd2, 32'd2);

        // Constant-level extremes, plain and inverted
        for (int c = 0; c < 4; c++) begin
            reg_write(2'd0, 32'h0, 4'b0001, 1'b1);
            reg_write(2'd2, {16'h0, hi_val[c]}, 4'b1111, 1'b1);
            reg_write(2'd0, {28'h0, inv[c], 3'b001}, 4'b0001, 1'b1);
            capture(21);
            check($sformatf("const_first_%0d", c), {31'h0, cap[0]}, 32'h0);
            check($sformatf("const_level_%0d", c), 32'(highs(1, 20)), 32'(exp_hi[c]));
        end

        // Collision interrupt latency, count and W1C
        reg_write(2'd0, 32'h4, 4'b0001, 1'b1);
        check("irq_idle", {31'h0, coldet_interrupt}, 32'h0);
        collision_detect = 1'b1;
        idle(2);
        check("irq_early", {31'h0, coldet_interrupt}, 32'h0);
        idle(1);
        check("irq_set", {31'h0, coldet_interrupt}, 32'h1);
        collision_detect = 1'b0;
        idle(3);
        read_check("status_one", 2'd3, 32'h0000_0101);
        reg_write(2'd3, 32'h1, 4'b0001, 1'b1);
        check("irq_cleared", {31'h0, coldet_interrupt}, 32'h0);
        read_check("status_w1c", 2'd3, 32'h0000_0100);
        reg_write(2'd3, 32'h0, 4'b0001, 1'b1);
        read_check("status_w0", 2'd3, 32'h0000_0100);
        reg_write(2'd3, 32'h4, 4'b0001, 1'b1);
        read_check("status_clrcnt", 2'd3, 32'h0);

        // Saturation and event coincident with clear
        repeat (300) begin
            collision_detect = 1'b1;
            idle(2);
            collision_detect = 1'b0;
            idle(2);
        end
        idle(4);
        read_check("count_sat", 2'd3, 32'h0000_FF01);
        reg_write(2'd3, 32'h5, 4'b0001, 1'b1);
        read_check("clear_all", 2'd3, 32'h0);
        collision_detect = 1'b1;
        idle(2);
        reg_write(2'd3, 32'h5, 4'b0001, 1'b1);
        collision_detect = 1'b0;
        idle(3);
        read_check("clear_vs_event", 2'd3, 32'h0000_0101);
        check("irq_after_race", {31'h0, coldet_interrupt}, 32'h1);

        // Asynchronous reset mid-period with collision held high
        reg_write(2'd2, 32'd5, 4'b1111, 1'b1);
        reg_write(2'd0, 32'h7, 4'b0001, 1'b1);
        idle(3);
        check("pre_rst_outs", {28'h0, econet_clken, econet_termen, econet_clkout, coldet_interrupt}, 32'hF);
        collision_detect = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async", {28'h0, econet_clken, econet_termen, econet_clkout, coldet_interrupt}, 32'h0);
        idle(3);
        reset_n = 1'b1;
        idle(10);
        check("post_rst_outs", {28'h0, econet_clken, econet_termen, econet_clkout, coldet_interrupt}, 32'h0);
        read_check("post_rst_status", 2'd3, 32'h0000_0002);
        read_check("post_rst_ctrl",   2'd0, 32'h0);
        read_check("post_rst_period", 2'd1, 32'd99);
        read_check("post_rst_high",   2'd2, 32'd25);
        collision_detect = 1'b0;
        idle(4);
        collision_detect = 1'b1;
        idle(4);
        read_check("post_rst_event", 2'd3, 32'h0000_0103);
        collision_detect = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/econet_hwctl_v2.md
ECONET_HWCTL_V2 -- requirements
Module: econet_hwctl_v2

Interface
REQ-001 Parameter CNT_W, default 16, width of clock-generator period/high-time counters (8..24).
REQ-002 Parameter DEF_PERIOD, default 99, reset value of PERIOD register (output period = PERIOD+1 clk cycles).
REQ-003 Parameter DEF_HIGH, default 25, reset value of HIGH register (clocks high per period; default gives 1/4 duty).
REQ-004 Parameter SYNC_STAGES, default 2, flip-flop depth of collision_detect synchroniser (min 2).
REQ-005 clk  input  1  system clock; sole clock of the block.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 wr  input  4  byte write strobes, wr[n] enables data_in[8n+7:8n].
REQ-008 select  input  1  block chip-select; writes occur only when select=1 and wr!=0.
REQ-009 addr  input  2  register word select: 0 CTRL, 1 PERIOD, 2 HIGH, 3 STATUS.
REQ-010 data_in  input  32  write data.
REQ-011 data_out  output  32  read data for addressed register, combinational, unused bits 0.
REQ-012 collision_detect  input  1  asynchronous collision indicator from line interface.
REQ-013 econet_clken  output  1  line clock driver enable (CTRL[0]).
REQ-014 econet_termen  output  1  terminator enable (CTRL[1]).
REQ-015 econet_clkout  output  1  generated Econet clock, registered.
REQ-016 coldet_interrupt  output  1  collision interrupt, level, = STATUS[0] & CTRL[2].

Function
REQ-017 CTRL: [0] clken, [1] termen, [2] irq_en, [3] clk_invert; written via wr[0].
REQ-018 PERIOD/HIGH: [CNT_W-1:0], written per byte lane; readback returns programmed (not shadow) value.
REQ-019 Generator holds shadow copies of PERIOD/HIGH, loaded only when counter wraps from PERIOD_shadow to 0, or while clken=0; reprogramming never produces a runt pulse.
REQ-020 Counter increments each clk while clken=1, wraps at PERIOD_shadow; counter held 0 while clken=0.
REQ-021 Raw clock = (counter < HIGH_shadow); HIGH=0 gives constant low, HIGH>PERIOD gives constant high.
REQ-022 econet_clkout registered = clken ? (raw XOR clk_invert) : 0; one-cycle latency from counter.
REQ-023 On clken 0->1, first output period starts with high phase at counter 0 using latest PERIOD/HIGH.
REQ-024 collision_detect passes SYNC_STAGES-FF synchroniser; a rising edge of synchronised signal is one event.
REQ-025 Event sets STATUS[0] (sticky) and increments STATUS[15:8] collision count, saturating at 255.
REQ-026 STATUS[1] reads live synchronised collision level.
REQ-027 STATUS write via wr[0]: data_in[0]=1 clears sticky, data_in[2]=1 clears count; zero bits no effect.
REQ-028 Event coincident with clear: sticky remains 1, count becomes 1.
REQ-029 Writes with select=0 or wr=0 have no effect; unwritten byte lanes unchanged.

Reset
REQ-030 reset_n low asynchronously forces: CTRL=0, PERIOD=DEF_PERIOD, HIGH=DEF_HIGH, shadows = defaults, counter=0, STATUS sticky/count=0, synchroniser=0, econet_clkout=0, econet_clken=0, econet_termen=0, coldet_interrupt=0.
REQ-031 Reset mid-period truncates output immediately; generation resumes only after clken rewritten to 1.
REQ-032 Collision held high across reset release shall not generate an event (synchroniser edge detector initialised to 0 counts only after first 0->1 seen post-reset; held-high input ignored).

Structure
REQ-033 Register address constants and CTRL/STATUS bit positions in shared package econet_pkg.
REQ-034 Clock generator (counter, shadows, output register) in sub-module econet_clkgen, parameter CNT_W.

Verification
REQ-035 Reset, write CTRL=0x1 -> clkout period 100 clk, high 25 clk, first edge high 1 cycle after write+1.
REQ-036 Running PERIOD=9/HIGH=5, write HIGH=2 mid-period -> current period completes 5-high, next period 2-high, no runt.
REQ-037 HIGH=0 -> clkout constant 0; HIGH=20, PERIOD=9 -> constant 1; clk_invert=1 inverts both.
REQ-038 CTRL=0x4, pulse collision_detect 3 clk -> coldet_interrupt high SYNC_STAGES+1 clk later, count=1; W1C STATUS[0] -> interrupt low.
REQ-039 300 collision pulses -> count reads 255; clear on same cycle as event -> sticky 1, count 1.
REQ-040 Assert reset_n low mid-period with collision_detect high -> all outputs 0 immediately; release -> no event recorded.
